// File: rtl/fp_normalize_round.sv
// Normalize, round to nearest-even and pack a wide significand/exponent pair into IEEE-754 binary32.
// Iterative: one normalize/denormalize step per cycle, with a single operation in flight.
module fp_normalize_round (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] in_significand,
  input  logic [9:0]  in_exponent,
  input  logic        in_sign,
  input  logic        in_is_nan,
  input  logic        in_is_inf,
  input  logic        flush_en,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result
);

  typedef enum logic [2:0] {IDLE, NORMALIZE, DENORM, ROUND, DONE} state_t;

  state_t             state;
  logic [47:0]        sig;
  // One extra bit of headroom so exp+1 on a right shift cannot wrap at the top of the input range.
  logic signed [10:0] exp_q;
  logic               sign_q;
  logic               sticky;

  logic               rnd_inc;
  logic [24:0]        rnd_mant;
  logic signed [10:0] rnd_exp;
  logic               rnd_unit;
  logic [22:0]        rnd_frac;
  logic [31:0]        rnd_result;

  assign in_ready = (state == IDLE);

  always_comb begin
    rnd_inc  = sig[22] & ((|sig[21:0]) | sticky | sig[23]);
    rnd_mant = {1'b0, sig[46:23]} + {24'd0, rnd_inc};
    rnd_unit = rnd_mant[23];
    rnd_frac = rnd_mant[22:0];
    rnd_exp  = exp_q;
    // Carry out of the units bit renormalizes to 1.0 * 2^(exp+1).
    if (rnd_mant[24]) begin
      rnd_unit = 1'b1;
      rnd_frac = rnd_mant[23:1];
      rnd_exp  = exp_q + 11'sd1;
    end
    if (rnd_exp >= 11'sd255)
      rnd_result = {sign_q, 8'hff, 23'h0};
    else
      rnd_result = {sign_q, rnd_unit ? rnd_exp[7:0] : 8'h00, rnd_frac};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_result <= 32'h0;
      sig        <= 48'h0;
      exp_q      <= 11'sd0;
      sign_q     <= 1'b0;
      sticky     <= 1'b0;
    end else if (flush_en) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sig    <= in_significand;
          exp_q  <= {in_exponent[9], in_exponent};
          sign_q <= in_sign;
          sticky <= 1'b0;
          if (in_is_nan) begin
            out_result <= 32'h7fc00000;
            out_valid  <= 1'b1;
            state      <= DONE;
          end else if (in_is_inf) begin
            out_result <= {in_sign, 8'hff, 23'h0};
            out_valid  <= 1'b1;
            state      <= DONE;
          end else if (in_significand == 48'h0) begin
            out_result <= {in_sign, 31'h0};
            out_valid  <= 1'b1;
            state      <= DONE;
          end else begin
            state <= NORMALIZE;
          end
        end
        NORMALIZE: begin
          if (sig[47]) begin
            sig    <= sig >> 1;
            exp_q  <= exp_q + 11'sd1;
            sticky <= sticky | sig[0];
          end else if (!sig[46] && sig[46:39] == 8'h0 && exp_q > 11'sd8) begin
            sig   <= sig << 8;
            exp_q <= exp_q - 11'sd8;
          end else if (!sig[46] && exp_q > 11'sd1) begin
            sig   <= sig << 1;
            exp_q <= exp_q - 11'sd1;
          end else if (exp_q < 11'sd1) begin
            state <= DENORM;
          end else begin
            state <= ROUND;
          end
        end
        DENORM: begin
          // Beyond 2^-24 below the subnormal scale nothing can survive rounding.
          if (exp_q < -11'sd24) begin
            out_result <= {sign_q, 31'h0};
            out_valid  <= 1'b1;
            state      <= DONE;
          end else begin
            sig    <= sig >> 1;
            exp_q  <= exp_q + 11'sd1;
            sticky <= sticky | sig[0];
            if (exp_q == 11'sd0) state <= ROUND;
          end
        end
        ROUND: begin
          out_result <= rnd_result;
          out_valid  <= 1'b1;
          state      <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_normalize_round.sv
// Directed-vector bench for fp_normalize_round: result, latency, stall, flush and reset behaviour.
module tb_fp_normalize_round;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [47:0] in_significand;
  logic [9:0]  in_exponent;
  logic        in_sign, in_is_nan, in_is_inf, flush_en;
  logic        out_valid, out_ready;
  logic [31:0] out_result;

  fp_normalize_round dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_significand(in_significand), .in_exponent(in_exponent), .in_sign(in_sign),
    .in_is_nan(in_is_nan), .in_is_inf(in_is_inf), .flush_en(flush_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] sig;
    logic [9:0]  exp;
    logic        sign, nan, inf;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic add(input logic [47:0] s, input logic [9:0] e, input logic sg, input logic nn,
                     input logic nf, input logic [31:0] r, input int l);
    vec_t v;
    v.sig = s; v.exp = e; v.sign = sg; v.nan = nn; v.inf = nf; v.res = r; v.lat = l;
    vecs.push_back(v);
  endtask

  // Drive one operand for one edge; lat counts edges from the accepting edge up to out_valid.
  task automatic issue(input vec_t v, output int lat);
    @(negedge clk);
    in_significand = v.sig; in_exponent = v.exp; in_sign = v.sign;
    in_is_nan = v.nan; in_is_inf = v.inf; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 300) check("timeout_out_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic handshake(input string name);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({name, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  // Watch for any spurious out_valid over a window; one comparison for the whole window.
  task automatic quiet(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      seen |= out_valid;
    end
    check(name, 32'(seen), 32'd0);
  endtask

  initial begin
    int   lat;
    vec_t v;
    reset = 1'b1; in_valid = 1'b0; in_significand = '0; in_exponent = '0;
    in_sign = 1'b0; in_is_nan = 1'b0; in_is_inf = 1'b0; flush_en = 1'b0; out_ready = 1'b0;

    //   significand                          exponent  s  nan inf  result          latency
    add(48'h1 << 46,                          10'd127,  0, 0,  0,   32'h3f800000,   3);
    add(48'h1 << 47,                          10'd127,  0, 0,  0,   32'h40000000,   4);
    add(48'h1 << 47,                          10'd254,  0, 0,  0,   32'h7f800000,   4);
    add((48'h1 << 46) | (48'h1 << 22),        10'd127,  0, 0,  0,   32'h3f800000,   3);
    add((48'h1 << 46) | (48'h3 << 22),        10'd127,  0, 0,  0,   32'h3f800002,   3);
    add(48'h1 << 38,                          10'd127,  0, 0,  0,   32'h3b800000,   4);
    add(48'h1 << 46,                          10'd0,    0, 0,  0,   32'h00400000,   4);
    add(48'h1 << 46,                          10'd127,  0, 1,  1,   32'h7fc00000,   1);
    add(48'h1 << 46,                          10'd127,  1, 0,  1,   32'hff800000,   1);
    add(48'h0,                                10'd127,  1, 0,  0,   32'h80000000,   1);
    add(48'h1 << 46,                          10'd127,  1, 0,  0,   32'hbf800000,   3);
    add(48'h1 << 45,                          10'd128,  0, 0,  0,   32'h3f800000,   4);
    add(48'h7fffffc00000,                     10'd127,  0, 0,  0,   32'h40000000,   3);
    add(48'h7fffffc00000,                     10'd254,  0, 0,  0,   32'h7f800000,   3);
    add(48'h1 << 46,                          10'h3e2,  1, 0,  0,   32'h80000000,   3);  // exp -30
    add(48'h1 << 46,                          10'h3ea,  0, 0,  0,   32'h00000001,  26);  // exp -22
    add(48'h1 << 46,                          10'h3e9,  0, 0,  0,   32'h00000000,  27);  // exp -23, tie
    add((48'h1 << 46) | 48'h1,                10'h3e9,  0, 0,  0,   32'h00000001,  27);  // sticky breaks tie
    add(48'h1 << 40,                          10'd3,    0, 0,  0,   32'h00080000,   5);
    add(48'h1,                                10'd173,  0, 0,  0,   32'h3f800000,  14);

    // Reset state
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_result", out_result, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    foreach (vecs[i]) begin
      check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
      issue(vecs[i], lat);
      check($sformatf("v%0d_result", i), out_result, vecs[i].res);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      handshake($sformatf("v%0d", i));
    end

    // Consumer stall: result held and no new operand accepted
    issue(vecs[0], lat);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("stall%0d_result", c), out_result, 32'h3f800000);
      check($sformatf("stall%0d_valid", c), 32'(out_valid), 32'd1);
      check($sformatf("stall%0d_in_ready", c), 32'(in_ready), 32'd0);
    end
    handshake("stall");

    // Flush during NORMALIZE: operand dropped
    v = vecs[0]; v.sig = 48'h1 << 30;
    @(negedge clk);
    in_significand = v.sig; in_exponent = 10'd127; in_sign = 1'b0;
    in_is_nan = 1'b0; in_is_inf = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("flush_norm_busy", 32'(in_ready), 32'd0);
    flush_en = 1'b1;
    @(negedge clk);
    flush_en = 1'b0;
    check("flush_norm_in_ready", 32'(in_ready), 32'd1);
    check("flush_norm_out_valid", 32'(out_valid), 32'd0);
    quiet("flush_norm_no_output", 20);

    // Flush wins over a simultaneous acceptance
    in_significand = 48'h1 << 46; in_exponent = 10'd127; in_valid = 1'b1; flush_en = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush_en = 1'b0;
    check("flush_accept_in_ready", 32'(in_ready), 32'd1);
    quiet("flush_accept_no_output", 10);

    // Flush wins over the output handshake in DONE
    issue(vecs[0], lat);
    flush_en = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    flush_en = 1'b0; out_ready = 1'b0;
    check("flush_done_out_valid", 32'(out_valid), 32'd0);
    check("flush_done_in_ready", 32'(in_ready), 32'd1);

    // Asynchronous reset mid-operation
    @(negedge clk);
    in_significand = 48'h1 << 46; in_exponent = 10'h3ea; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_result", out_result, 32'h0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    quiet("midrst_no_output", 40);

    // Block still works after the flushes and reset
    issue(vecs[4], lat);
    check("post_result", out_result, 32'h3f800002);
    check("post_latency", 32'(lat), 32'd3);
    handshake("post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fp_normalize_round.md
FP_NORMALIZE_ROUND -- requirements
Module: fp_normalize_round

Interface
REQ-001 SHALL have port clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port in_valid, input, 1 bit: the input operand is valid.
REQ-004 SHALL have port in_ready, output, 1 bit: the block can accept an operand; high only in IDLE.
REQ-005 SHALL have port in_significand, input, 48 bits: unsigned magnitude; bit 46 is the units position.
REQ-006 SHALL have port in_exponent, input, 10 bits: signed two's-complement biased exponent (bias 127).
REQ-007 SHALL have port in_sign, input, 1 bit: sign of the result.
REQ-008 SHALL have ports in_is_nan and in_is_inf, input, 1 bit each: special-case flags from the upstream stage.
REQ-009 SHALL have port flush_en, input, 1 bit: abort any in-flight operation.
REQ-010 SHALL have port out_valid, output, 1 bit: out_result is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 SHALL have port out_result, output, 32 bits: IEEE-754 binary32 result.

Function
REQ-013 SHALL represent the value as (-1)^sign * sig * 2^(exp-127-46).
REQ-014 SHALL implement states IDLE, NORMALIZE, DENORM, ROUND and DONE.
REQ-015 SHALL accept an operand when in_valid && in_ready, latching all inputs and clearing the internal sticky bit.
REQ-016 SHALL make the following transitions on acceptance:
- in_is_nan: to DONE with result 32'h7fc00000 (canonical quiet NaN). NaN has priority over inf.
- otherwise in_is_inf: to DONE with result {sign, 8'hff, 23'h0}.
- otherwise significand == 0: to DONE with result {sign, 31'h0}.
- otherwise: to NORMALIZE.
REQ-017 SHALL perform exactly one step per cycle in NORMALIZE, in this priority order:
- bit 47 set: shift right 1 and exp += 1; the shifted-out bit ORs into sticky.
- bit 46 clear, bits[46:39] == 0 and exp > 8: shift left 8 and exp -= 8.
- bit 46 clear and exp > 1: shift left 1 and exp -= 1.
- otherwise: go to DENORM if exp < 1, else go to ROUND.
REQ-018 SHALL handle DENORM as follows:
- if exp < -24: go to DONE with signed zero.
- otherwise, each cycle: shift right 1, exp += 1, sticky |= the shifted-out bit.
- when exp == 1: go to ROUND.
REQ-019 SHALL round in ROUND to nearest-even:
- lsb = sig[23], guard = sig[22], sticky = |sig[21:0] | sticky reg.
- increment sig[46:23] when guard && (sticky || lsb).
REQ-020 SHALL, on a rounding carry out of bit 46, shift right 1 and increment exp.
REQ-021 SHALL produce the packed result {sign, field, sig[45:23]}, where field = exp[7:0] if bit 46 is set after rounding, else 0.
REQ-022 SHALL produce {sign, 8'hff, 23'h0} when exp >= 255 after rounding.
REQ-023 SHALL go to DONE after ROUND.
REQ-024 SHALL hold out_valid high and out_result stable in DONE until out_ready; on out_valid && out_ready it SHALL return to IDLE, with in_ready high the next cycle.
REQ-025 SHALL have latency from the acceptance edge to out_valid of 1 cycle for specials and (NORMALIZE steps + DENORM steps + 2) otherwise; the minimum for a normal operand is 3.
REQ-026 SHALL, when flush_en is asserted in any state, go to IDLE at the next edge and deassert out_valid.
REQ-027 SHALL give flush_en priority over a simultaneous acceptance or output handshake; a flushed operand is never output.
REQ-028 SHALL not pipeline operations: at most one operation is in flight.

Reset
REQ-029 SHALL, while reset is asserted, force state=IDLE, out_valid=0, out_result=0, internal significand/exponent/sign/sticky=0; in_ready SHALL be 1 after reset releases.
REQ-030 SHALL, when reset is asserted mid-operation, discard the operation with no out_valid pulse.

Verification
REQ-031 SHALL cover: sig=1<<46, exp=127, sign=0 -> out_result=32'h3f800000, out_valid 3 cycles after accept.
REQ-032 SHALL cover: sig=1<<47, exp=127 -> 32'h40000000 with latency 4; sig=1<<47, exp=254 -> 32'h7f800000.
REQ-033 SHALL cover: sig=(1<<46)|(1<<22), exp=127 -> 32'h3f800000 (tie, even); sig=(1<<46)|(1<<23)|(1<<22) -> 32'h3f800002.
REQ-034 SHALL cover: sig=1<<38, exp=127 -> one 8-bit step -> 32'h3b800000, latency 4; sig=1<<46, exp=0 -> 32'h00400000.
REQ-035 SHALL cover: in_is_nan=1 with in_is_inf=1 -> 32'h7fc00000 one cycle after accept; in_is_inf=1, sign=1 -> 32'hff800000.
REQ-036 SHALL cover: out_ready held low for 5 cycles -> out_result stable and in_ready low; flush_en asserted during NORMALIZE -> in_ready=1 next cycle and no out_valid.
